// File: rtl/query_patch_mem_wb_pkg.sv
// Shared types and geometry helpers for the query-patch memory with its Wishbone slave.
package query_patch_pkg;

    localparam logic [31:0] DEFAULT_WB_BASE = 32'h3000_0000;
    localparam logic [31:0] DEFAULT_WB_MASK = 32'hFFF0_0000;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        ACK
    } wb_state_e;

    function automatic int calc_pw(input int data_width, input int patch_size);
        return data_width * patch_size;
    endfunction

    // A single-element patch still needs a one-bit element field in the address.
    function automatic int calc_ew(input int patch_size);
        return (patch_size > 1) ? $clog2(patch_size) : 1;
    endfunction

endpackage

// File: rtl/query_patch_mem_wb_if.sv
// Wishbone slave bus as seen by the query-patch memory (32-bit data and address).
interface query_patch_mem_wb_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/query_patch_mem_wb_ram.sv
// 1RW + 1R synchronous patch array; read registers only update on a read so they hold between reads.
module query_patch_ram #(
    parameter int PW         = 55,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [PW-1:0]         wdata0,
    output logic [PW-1:0]         rdata0,
    input  logic                  en1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [PW-1:0]         rdata1
);

    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en0 && we0) begin
            mem[addr0] <= wdata0;
        end
    end

    // Port 1 sampling the array before port 0's write lands gives old-data semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (en0 && !we0) begin
                rdata0 <= mem[addr0];
            end
            if (en1) begin
                rdata1 <= mem[addr1];
            end
        end
    end

endmodule

// File: rtl/query_patch_mem_wb.sv
// Dual-port query-patch memory with a same-clock Wishbone slave doing element read-modify-write.
module query_patch_mem_wb
    import query_patch_pkg::*;
#(
    parameter int          DATA_WIDTH = 11,
    parameter int          PATCH_SIZE = 5,
    parameter int          ADDR_WIDTH = 9,
    parameter int          DEPTH      = 512,
    parameter logic [31:0] WB_BASE    = DEFAULT_WB_BASE,
    parameter logic [31:0] WB_MASK    = DEFAULT_WB_MASK,
    localparam int         PW         = calc_pw(DATA_WIDTH, PATCH_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [PW-1:0]         wpatch0,
    output logic [PW-1:0]         rpatch0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [PW-1:0]         rpatch1,
    input  logic                  wb_mode,
    query_patch_mem_wb_if.slave   wb
);

    localparam int EW = calc_ew(PATCH_SIZE);

    wb_state_e state, state_nxt;

    logic [EW-1:0]         elem_q;
    logic [ADDR_WIDTH-1:0] patch_q;
    logic                  oor_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [PW-1:0]         merge_q;
    logic [31:0]           dat_o_q;
    logic                  rd0_pend;
    logic [PW-1:0]         rpatch0_hold;

    logic [31:0]           offset, elem_full, patch_full;
    logic                  sel_hit, req_oor;
    logic                  fsm_busy, native_en0;
    logic                  ram_en0, ram_we0, ram_en1;
    logic [ADDR_WIDTH-1:0] ram_addr0;
    logic [PW-1:0]         ram_wdata0, ram_rdata0;
    logic [DATA_WIDTH-1:0] elem_val;
    logic [PW-1:0]         merged;
    logic                  unused_bits;

    // Patch index is taken from every unmasked bit so indices past the array are caught.
    assign offset     = wb.wbs_adr_i & ~WB_MASK;
    assign elem_full  = (offset >> 2) & ((32'd1 << EW) - 32'd1);
    assign patch_full = offset >> (EW + 2);
    assign sel_hit    = wb.wbs_stb_i && wb.wbs_cyc_i && ((wb.wbs_adr_i & WB_MASK) == WB_BASE);
    assign req_oor    = (elem_full >= PATCH_SIZE) || (patch_full >= DEPTH);
    assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_dat_i[31:DATA_WIDTH]};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_hit) state_nxt = wb_mode ? RD : ACK;
            RD:      state_nxt = MRG;
            MRG:     state_nxt = we_q ? WR : ACK;
            WR:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Port 0 stays with the FSM until its access is done, even if wb_mode drops mid-transaction.
    always_comb begin
        fsm_busy   = (state == RD) || (state == MRG) || (state == WR);
        native_en0 = !wb_mode && !fsm_busy && !csb0;
        ram_en0    = native_en0 || (state == RD) || ((state == WR) && !oor_q);
        ram_we0    = native_en0 ? !web0 : (state == WR);
        ram_addr0  = native_en0 ? addr0 : patch_q;
        ram_wdata0 = native_en0 ? wpatch0 : merge_q;
        ram_en1    = !wb_mode && !csb1;
    end

    always_comb begin
        elem_val = '0;
        merged   = ram_rdata0;
        for (int e = 0; e < PATCH_SIZE; e++) begin
            if (elem_q == EW'(e)) begin
                elem_val = ram_rdata0[e*DATA_WIDTH +: DATA_WIDTH];
                merged[e*DATA_WIDTH +: DATA_WIDTH] = wdat_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q       <= '0;
            patch_q      <= '0;
            oor_q        <= 1'b0;
            we_q         <= 1'b0;
            wdat_q       <= '0;
            merge_q      <= '0;
            dat_o_q      <= '0;
            rd0_pend     <= 1'b0;
            rpatch0_hold <= '0;
        end else begin
            rd0_pend <= native_en0 && web0;
            if (rd0_pend) begin
                rpatch0_hold <= ram_rdata0;
            end
            if ((state == IDLE) && sel_hit) begin
                elem_q  <= elem_full[EW-1:0];
                patch_q <= patch_full[ADDR_WIDTH-1:0];
                oor_q   <= req_oor;
                we_q    <= wb.wbs_we_i;
                wdat_q  <= wb.wbs_dat_i[DATA_WIDTH-1:0];
                if (!wb_mode) begin
                    dat_o_q <= '0;
                end
            end
            if (state == MRG) begin
                if (we_q) begin
                    merge_q <= merged;
                    dat_o_q <= '0;
                end else begin
                    dat_o_q <= oor_q ? 32'd0 : 32'(elem_val);
                end
            end
        end
    end

    assign rpatch0      = rd0_pend ? ram_rdata0 : rpatch0_hold;
    assign wb.wbs_ack_o = (state == ACK);
    assign wb.wbs_dat_o = dat_o_q;

    query_patch_ram #(
        .PW         (PW),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .en0    (ram_en0),
        .we0    (ram_we0),
        .addr0  (ram_addr0),
        .wdata0 (ram_wdata0),
        .rdata0 (ram_rdata0),
        .en1    (ram_en1),
        .addr1  (addr1),
        .rdata1 (rpatch1)
    );

endmodule

// File: doc/query_patch_mem_wb.md
# query_patch_mem_wb

Parametrised dual-port query-patch memory with an integrated, same-clock Wishbone slave for element-granular host access. Native port 0 (read/write) and port 1 (read-only) serve the ANN search datapath at full patch width. When `wb_mode` is high, the Caravel host reads and writes individual patch elements over the 32-bit bus through a read-modify-write FSM. This is the successor to the two-clock query memory: it adds generalised geometry, element addressing, out-of-range handling and a defined arbitration rule.

## Interface
- `DATA_WIDTH`, 11: bits per patch element.
- `PATCH_SIZE`, 5: elements per patch; `PW = DATA_WIDTH*PATCH_SIZE`.
- `ADDR_WIDTH`, 9: patch address width.
- `DEPTH`, 512: patches stored, `DEPTH <= 2**ADDR_WIDTH`.
- `WB_BASE`, 32'h3000_0000: bus window base.
- `WB_MASK`, 32'hFFF0_0000: bits compared against `WB_BASE` for slave select.

- `clk` in 1: single clock for memory and bus.
- `rst_n` in 1: asynchronous, active-low reset.
- `csb0`, `web0` in 1 each: port 0 chip select and write enable, both active-low.
- `addr0` in ADDR_WIDTH: port 0 address.
- `wpatch0` in PW: port 0 write data.
- `rpatch0` out PW: port 0 read data.
- `csb1` in 1: port 1 chip select, active-low.
- `addr1` in ADDR_WIDTH: port 1 address.
- `rpatch1` out PW: port 1 read data.
- `wb_mode` in 1: 1 gives the bus ownership of port 0 and gates port 1.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` in 4: byte selects, ignored.
- `wbs_dat_i`, `wbs_adr_i` in 32 each: bus write data and address.
- `wbs_ack_o` out 1: bus acknowledge.
- `wbs_dat_o` out 32: bus read data.

## Operation
- Element `e` of a patch occupies bits `[e*DATA_WIDTH +: DATA_WIDTH]`.
- Address decode:
  - Selected when `(wbs_adr_i & WB_MASK) == WB_BASE`.
  - `EW = $clog2(PATCH_SIZE)`; element index = `adr[EW+1:2]`; patch index = `adr[ADDR_WIDTH+EW+1:EW+2]`.
- Native mode (`wb_mode=0`):
  - Port 0 writes `wpatch0` when `csb0=0,web0=0`; reads when `csb0=0,web0=1`.
  - Port 1 reads when `csb1=0`.
  - Selected bus requests are acked in 1 cycle with `wbs_dat_o=0`, and writes are dropped, so the bus never hangs.
- Bus mode (`wb_mode=1`):
  - Native port 0 and port 1 are ignored; `rpatch0`/`rpatch1` hold their last values.
- FSM states: IDLE, RD, MRG, WR, ACK.
  - IDLE: on a selected `stb&cyc`, latch address, data and we, then go to RD. `wb_mode` is sampled only here.
  - RD: issue a port 0 read of the patch, then go to MRG.
  - MRG, read: place the element zero-extended into `wbs_dat_o`, then go to ACK.
  - MRG, write: replace the element with `wbs_dat_i[DATA_WIDTH-1:0]`, then go to WR.
  - WR: write the merged patch, then go to ACK.
  - ACK: `wbs_ack_o=1` for exactly one cycle, then return to IDLE.
- Out of range (element index >= PATCH_SIZE, or patch index >= DEPTH): the FSM still traverses its states and acks. Reads return 0 and writes do not modify memory.
- Port 0 read/write to the same address in one cycle cannot occur; the FSM serialises it.
- Port 1 reading the address port 0 is writing in the same cycle returns old data.

## Timing
- Native reads have 1-cycle latency: `rpatch*` is valid the cycle after a read select and holds until the next read.
- Bus read: request seen at cycle 0 (IDLE), ack and data at cycle 3.
- Bus write: ack at cycle 4.
- Native-mode ack for a selected request: cycle 1.
- Master must drop `stb` after ack. The next request is accepted no earlier than 1 cycle after ack.
- A `wb_mode` change during a transaction takes effect after ACK.
- Reset values: `rpatch0=0`, `rpatch1=0`, `wbs_ack_o=0`, `wbs_dat_o=0`, FSM=IDLE.
- Memory contents are not cleared by reset. Reset mid-transaction aborts it: no ack, and a write not yet in WR is lost.

## Structure
- Package `query_patch_pkg`: `PW`/`EW` derivation functions, FSM state enum, default `WB_BASE`/`WB_MASK`.
- Sub-module `query_patch_ram`: 1RW+1R synchronous array, `DEPTH x PW`, with no reset on the array.
- Top level holds the decode, the FSM, the element merge/extract mux and the port muxing.

## Test plan
- Native write `{44'b0,11'h1}` to addr 0 via port 0, then port 1 read of addr 0 -> `rpatch1=55'h1` one cycle after `csb1` low.
- `wb_mode=1`, bus write 0x7FF to patch 3 element 2 (`adr=WB_BASE+0x6*4*... `, i.e. patch 3, elem 2) -> ack at cycle 4; native read shows only bits [32:22] changed to 0x7FF.
- Bus read of patch 3 element 2 -> `wbs_dat_o=32'h7FF` with ack at cycle 3; element 4 of the same patch reads its original value.
- Bus read of element index 6 and of patch index 512 -> ack, `wbs_dat_o=0`. Bus write to element index 6 -> memory unchanged.
- `wb_mode=0` with a selected bus write -> ack at cycle 1, data 0, memory unchanged. An address outside the window -> no ack.
- Assert `rst_n=0` during WR of a bus write -> no ack, outputs 0, FSM IDLE. A subsequent transaction completes normally.
